// File: rtl/fifo_sync_ext.sv
// Single-clock FIFO with selectable FWFT/standard read, occupancy count, programmable
// almost flags, sticky error flags, synchronous flush and write-while-full pass-through.
module fifo_sync_ext #(
    parameter int DATA_BITS     = 8,
    parameter int ADDR_BITS     = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = (1 << ADDR_BITS) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   cnt;
    logic                 do_rd;
    logic                 do_wr;

    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign count        = cnt;
    assign empty        = (cnt == '0);
    assign full         = (cnt == (ADDR_BITS+1)'(DEPTH));
    assign almost_full  = (int'(cnt) >= AFULL_THRESH);
    assign almost_empty = (int'(cnt) <= AEMPTY_THRESH);

    // Storage is deliberately not reset; a flush only discards the pending write.
    always_ff @(posedge clk) begin
        if (do_wr && !clr) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                cnt <= cnt + 1'b1;
            end else if (do_rd && !do_wr) begin
                cnt <= cnt - 1'b1;
            end
            if (wr_en && !do_wr) begin
                overflow <= 1'b1;
            end
            if (rd_en && !do_rd) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue is presented combinationally; zero while empty.
            assign data_out = empty ? '0 : mem[rd_ptr];
            assign valid    = !empty;
        end else begin : g_std
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_out <= '0;
                    valid    <= 1'b0;
                end else if (clr) begin
                    data_out <= '0;
                    valid    <= 1'b0;
                end else if (do_rd) begin
                    data_out <= mem[rd_ptr];
                    valid    <= 1'b1;
                end else begin
                    valid    <= 1'b0;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_fifo_sync_ext.sv
// Drives a standard-mode and an FWFT-mode instance with the same stimulus and
// compares both against a queue-based reference every cycle.
module tb_fifo_sync_ext;
    logic       clk = 1'b0;
    logic       rst, clr, wr_en, rd_en;
    logic [7:0] data_in;

    logic [7:0] s_dout, f_dout;
    logic       s_vld, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic       f_vld, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0] s_cnt, f_cnt;

    int total = 0;
    int bad   = 0;

    fifo_sync_ext #(.DATA_BITS(8), .ADDR_BITS(4), .FWFT(0), .AFULL_THRESH(14), .AEMPTY_THRESH(2)) u_std (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(s_dout), .valid(s_vld), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
        .overflow(s_ovf), .underflow(s_unf));

    fifo_sync_ext #(.DATA_BITS(8), .ADDR_BITS(4), .FWFT(1), .AFULL_THRESH(14), .AEMPTY_THRESH(2)) u_fwft (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(f_dout), .valid(f_vld), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
        .overflow(f_ovf), .underflow(f_unf));

    always #5 clk = ~clk;

    // Reference: a plain queue of words plus the sticky flags and the registered read port.
    logic [7:0] q[$];
    logic       m_ovf, m_unf, m_sv;
    logic [7:0] m_sd;

    typedef struct {
        logic       c, w, r;
        logic [7:0] din;
        int         cnt;
        logic       vld;
        logic [7:0] dout;
        logic       ovf, unf;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_sv = 1'b0; m_sd = 8'h00;
    endtask

    task automatic model_step();
        bit rok, wok;
        if (clr) begin
            model_reset();
        end else begin
            rok = rd_en && (q.size() != 0);
            wok = wr_en && ((q.size() < 16) || rok);
            if (rok) begin
                m_sd = q.pop_front();
                m_sv = 1'b1;
            end else begin
                m_sv = 1'b0;
            end
            if (wok) q.push_back(data_in);
            if (wr_en && !wok) m_ovf = 1'b1;
            if (rd_en && !rok) m_unf = 1'b1;
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("std count", 32'(s_cnt), 32'(n));
        chk("fwft count", 32'(f_cnt), 32'(n));
        chk("std full", 32'(s_full), 32'(n == 16));
        chk("fwft full", 32'(f_full), 32'(n == 16));
        chk("std empty", 32'(s_empty), 32'(n == 0));
        chk("fwft empty", 32'(f_empty), 32'(n == 0));
        chk("std almost_full", 32'(s_af), 32'(n >= 14));
        chk("fwft almost_full", 32'(f_af), 32'(n >= 14));
        chk("std almost_empty", 32'(s_ae), 32'(n <= 2));
        chk("fwft almost_empty", 32'(f_ae), 32'(n <= 2));
        chk("std overflow", 32'(s_ovf), 32'(m_ovf));
        chk("fwft overflow", 32'(f_ovf), 32'(m_ovf));
        chk("std underflow", 32'(s_unf), 32'(m_unf));
        chk("fwft underflow", 32'(f_unf), 32'(m_unf));
        chk("std valid", 32'(s_vld), 32'(m_sv));
        chk("std data_out", 32'(s_dout), 32'(m_sd));
        chk("fwft valid", 32'(f_vld), 32'(n != 0));
        chk("fwft data_out", 32'(f_dout), (n != 0) ? 32'(q[0]) : 32'h0);
    endtask

    task automatic cycle(input logic c, input logic w, input logic r, input logic [7:0] d);
        clr = c; wr_en = w; rd_en = r; data_in = d;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    function automatic void add(input logic c, input logic w, input logic r, input logic [7:0] din,
                                input int cnt, input logic vld, input logic [7:0] dout,
                                input logic ovf, input logic unf);
        vec_t v;
        v.c = c; v.w = w; v.r = r; v.din = din; v.cnt = cnt;
        v.vld = vld; v.dout = dout; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endfunction

    initial begin
        // Hand-derived expectations for the standard-mode instance.
        for (int i = 1; i <= 16; i++) add(0, 1, 0, 8'(i), i, 0, 8'h00, 0, 0);
        for (int i = 1; i <= 16; i++) add(0, 0, 1, 8'h00, 16 - i, 1, 8'(i), 0, 0);
        for (int i = 1; i <= 16; i++) add(0, 1, 0, 8'(i), i, 0, 8'h10, 0, 0);
        add(0, 1, 0, 8'h99, 16, 0, 8'h10, 1, 0);
        add(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        for (int i = 1; i <= 16; i++) add(0, 1, 0, 8'(i), i, 0, 8'h00, 0, 0);
        add(0, 1, 1, 8'hAA, 16, 1, 8'h01, 0, 0);
        for (int k = 1; k <= 16; k++) add(0, 0, 1, 8'h00, 16 - k, 1, (k < 16) ? 8'(k + 1) : 8'hAA, 0, 0);
        add(0, 1, 1, 8'h55, 1, 0, 8'hAA, 0, 1);
        add(0, 0, 1, 8'h00, 0, 1, 8'h55, 0, 1);
        add(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);

        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset empty", 32'(s_empty), 32'd1);
        chk("reset almost_empty", 32'(s_ae), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            cycle(vecs[i].c, vecs[i].w, vecs[i].r, vecs[i].din);
            chk($sformatf("vec%0d count", i), 32'(s_cnt), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d valid", i), 32'(s_vld), 32'(vecs[i].vld));
            chk($sformatf("vec%0d data_out", i), 32'(s_dout), 32'(vecs[i].dout));
            chk($sformatf("vec%0d overflow", i), 32'(s_ovf), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d underflow", i), 32'(s_unf), 32'(vecs[i].unf));
        end

        // FWFT: word written to empty FIFO appears next cycle, pop clears it.
        cycle(0, 1, 0, 8'h33);
        chk("fwft first valid", 32'(f_vld), 32'd1);
        chk("fwft first data", 32'(f_dout), 32'h33);
        cycle(0, 0, 1, 8'h00);
        chk("fwft popped valid", 32'(f_vld), 32'd0);
        chk("fwft popped data", 32'(f_dout), 32'h00);

        // Asynchronous reset mid-stream with a write pending.
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'(8'hC0 + i));
        wr_en = 1'b1; data_in = 8'h99;
        #2;
        rst = 1'b1;
        #1;
        chk("async rst count", 32'(s_cnt), 32'd0);
        chk("async rst empty", 32'(s_empty), 32'd1);
        chk("async rst fwft valid", 32'(f_vld), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b0;
        cycle(0, 1, 0, 8'h77);
        chk("post rst fwft data", 32'(f_dout), 32'h77);
        cycle(0, 0, 1, 8'h00);
        chk("post rst std data", 32'(s_dout), 32'h77);
        chk("post rst std valid", 32'(s_vld), 32'd1);

        // Randomized traffic: a fill-biased phase, then a drain-biased phase.
        for (int i = 0; i < 800; i++) begin
            logic c, w, r;
            c = ($urandom_range(0, 59) == 0);
            if (i < 400) begin
                w = ($urandom_range(0, 99) < 70);
                r = ($urandom_range(0, 99) < 35);
            end else begin
                w = ($urandom_range(0, 99) < 35);
                r = ($urandom_range(0, 99) < 70);
            end
            cycle(c, w, r, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_sync_ext.md
Name: fifo_sync_ext

Overview:
- Parametrised synchronous single-clock FIFO; next generation of the team's basic sync FIFO.
- Adds the following:
  - selectable first-word-fall-through (FWFT) or standard read mode;
  - occupancy count output;
  - programmable almost-full and almost-empty flags;
  - sticky overflow and underflow error flags;
  - synchronous flush;
  - write-while-full pass-through.
- Used as the general buffering primitive between streaming blocks in one clock domain.

Parameters:
- DATA_BITS, 8: word width.
- ADDR_BITS, 4: pointer width. DEPTH = 2**ADDR_BITS.
- FWFT, 0: 0 = standard mode (read data 1 cycle after rd_en); 1 = first-word-fall-through.
- AFULL_THRESH, DEPTH-2: almost_full asserted when count >= AFULL_THRESH. Legal range 1..DEPTH.
- AEMPTY_THRESH, 2: almost_empty asserted when count <= AEMPTY_THRESH. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush, active-high.
- wr_en  in  1  write request.
- data_in  in  DATA_BITS  write data.
- rd_en  in  1  read request; in FWFT mode this is the pop/acknowledge.
- data_out  out  DATA_BITS  read data.
- valid  out  1  data_out holds a valid word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  ADDR_BITS+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst async, active-high; clock clk):
  - wr_ptr, rd_ptr, count = 0.
  - overflow, underflow = 0.
  - data_out = 0, valid = 0.
  - Result: empty = 1, almost_empty = 1, full = 0, almost_full = 0 (given legal thresholds).
  - Memory contents undefined and not reset.
- Read/write acceptance:
  - do_rd = rd_en && !empty.
  - do_wr = wr_en && (!full || do_rd). A write while full is accepted when a read is accepted in the same cycle.
  - A write to an empty FIFO is never readable in the same cycle; no bypass.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_BITS wide and wrap modulo DEPTH naturally.
  - On do_wr: mem[wr_ptr] <= data_in; wr_ptr increments.
  - On do_rd: rd_ptr increments.
- count update:
  - +1 on do_wr only.
  - -1 on do_rd only.
  - Unchanged when both or neither occur.
  - count never exceeds DEPTH and never goes below 0.
- Flags:
  - full, empty, almost_full and almost_empty are combinational decodes of the count register only, so they change on the clock edge after the causing access.
- Standard mode (FWFT=0):
  - On do_rd: data_out <= mem[rd_ptr] and valid <= 1 at that edge (1-cycle latency).
  - Otherwise valid <= 0 and data_out holds its last value.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] whenever count != 0; data_out = 0 when empty.
  - valid = !empty.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
  - rd_en with valid = 1 pops the word; the next word is presented on the following cycle.
- Error flags:
  - overflow <= 1 when wr_en && !do_wr.
  - underflow <= 1 when rd_en && !do_rd.
  - Both hold until rst or clr. Rejected accesses leave the pointers, count and memory unchanged.
- Flush (clr):
  - Same resets as rst, applied synchronously.
  - clr has priority over wr_en/rd_en in the same cycle; those accesses are discarded and do not set the error flags.
- Reset mid-operation:
  - rst asserted at any time clears state immediately, regardless of pending accesses.
  - After rst deasserts, the first write behaves exactly as in a freshly reset FIFO.

Test Plan:
- Config: DATA_BITS=8, ADDR_BITS=4, FWFT=0.
  - Write 0x01..0x10 (16 words) -> full=1, count=16, almost_full from count=14. Read 16 -> data_out sequence 0x01..0x10 with valid one cycle after each rd_en; empty=1 at end.
  - Fill to 16, then a 17th write -> overflow=1 and count stays 16. Then clr -> count=0, overflow=0, empty=1.
  - Fill to 16, then wr_en+rd_en in the same cycle with data_in=0xAA -> count stays 16, read returns 0x01. Draining returns 0xAA as the last word, which checks wrap-around.
  - Empty FIFO with rd_en=1 and wr_en=1 (0x55) -> read rejected, underflow=1, count=1. Next read returns 0x55.
- Config: FWFT=1.
  - Write 0x33 to empty -> next cycle valid=1, data_out=0x33. Then rd_en -> next cycle valid=0, data_out=0.
- Write 5 words, then pulse rst mid-stream while wr_en=1 -> count=0 and empty=1 immediately. After release, write 0x77 and read -> 0x77.
